mem_req_responder: RTL and testbench

MEM_REQ_RESPONDER -- requirements
Module: mem_req_responder

---
 rtl/mem_req_responder_if.sv | 23 ++
 rtl/mem_req_responder.sv | 148 ++++++++++++++
 tb/tb_mem_req_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_responder_if.sv
// Request/response bus between the core and mem_req_responder.
// The core drives the i_* signals and the responder drives the o_* signals.
interface mem_req_responder_if;
  logic         i_req;
  logic         i_we;
  logic [31:0]  i_addr;
  logic [31:0]  i_wdata;
  logic [2:0]   i_ctrl;
  logic         o_busy;
  logic [127:0] o_rdata;
  logic         o_done;
  logic         o_fault;

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_ctrl,
    input  o_busy, o_rdata, o_done, o_fault
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_ctrl,
    output o_busy, o_rdata, o_done, o_fault
  );
endinterface

// File: rtl/mem_req_responder.sv
// Fixed-latency 128-bit-line memory responder for core loads/stores (IDLE -> WAIT -> RESP).
// Define MEM_RESP_ALIGN_CHECK_EN to fault misaligned half/word accesses instead of aligning them.
module mem_req_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  mem_req_responder_if.slave   bus
);
  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned LINE_W    = 128;
  localparam int unsigned SPAN_LOG2 = DEPTH_LOG2 + 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept_c, access_c;

  logic                req_we;
  logic [31:0]         req_addr, req_wdata;
  logic [1:0]          req_size;

  logic                busy_q, done_q, fault_q;
  logic [LINE_W-1:0]   rdata_q;

  logic [31:0]           off_c;
  logic [DEPTH_LOG2-1:0] idx_c;
  logic [3:0]            lane_c;
  logic [15:0]           be_base_c, be_c;
  logic                  in_range_c, size_bad_c, misalign_c, fault_c, mem_we_c;
  logic [LINE_W-1:0]     old_line_c, wline_c, new_line_c, rdata_c;

  logic [LINE_W-1:0]   mem [DEPTH];

  logic                unused_ctrl;
  assign unused_ctrl = bus.i_ctrl[2];

  // Next-state logic; the access happens on the WAIT->RESP edge so RESP shows it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    access_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_req) begin
          accept_c = 1'b1;
          cnt_d    = CNT_W'(LATENCY - 1);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          access_c = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address decode, byte-enable generation and read-modify-write of the line.
  always_comb begin
    off_c      = req_addr - BASE_ADDR;
    in_range_c = (off_c >> SPAN_LOG2) == 32'd0;
    idx_c      = off_c[SPAN_LOG2-1:4];
    lane_c     = req_addr[3:0];
    be_base_c  = 16'h0000;
    size_bad_c = 1'b0;
    misalign_c = 1'b0;
    case (req_size)
      2'd0: be_base_c = 16'h0001;
      2'd1: begin
        be_base_c = 16'h0003;
`ifdef MEM_RESP_ALIGN_CHECK_EN
        misalign_c = lane_c[0];
`else
        lane_c[0] = 1'b0;
`endif
      end
      2'd2: begin
        be_base_c = 16'h000F;
`ifdef MEM_RESP_ALIGN_CHECK_EN
        misalign_c = lane_c[1:0] != 2'b00;
`else
        lane_c[1:0] = 2'b00;
`endif
      end
      default: size_bad_c = 1'b1;
    endcase
    fault_c    = !in_range_c || size_bad_c || misalign_c;
    old_line_c = mem[idx_c];
    wline_c    = LINE_W'(req_wdata) << {lane_c, 3'b000};
    be_c       = be_base_c << lane_c;
    for (int i = 0; i < 16; i++) begin
      new_line_c[8*i +: 8] = (req_we && be_c[i]) ? wline_c[8*i +: 8] : old_line_c[8*i +: 8];
    end
    rdata_c  = fault_c ? '0 : new_line_c;
    mem_we_c = access_c && req_we && !fault_c;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      rdata_q   <= '0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_size  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == WAIT);
      done_q  <= (state_d == RESP);
      if (accept_c) begin
        req_we    <= bus.i_we;
        req_addr  <= bus.i_addr;
        req_wdata <= bus.i_wdata;
        req_size  <= bus.i_ctrl[1:0];
      end
      if (access_c) begin
        rdata_q <= rdata_c;
        fault_q <= fault_c;
      end
    end
  end

  // Line storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (mem_we_c) mem[idx_c] <= new_line_c;
  end

  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_fault = fault_q;
  assign bus.o_rdata = rdata_q;
endmodule

// File: tb/tb_mem_req_responder.sv
// Scoreboard bench for mem_req_responder: directed loads/stores push expected responses,
// a negedge monitor pops and compares data, fault and completion cycle on every o_done.
module tb_mem_req_responder;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned LAT  = 2;

  typedef struct {
    logic [127:0] rdata;
    logic [127:0] mask;
    logic         fault;
    int           cyc;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_X = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  exp_t sb[$];

  mem_req_responder_if bus();

  mem_req_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .CLK(CLK), .RST_X(RST_X), .bus(bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every o_done must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (RST_X && bus.o_done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 128'(1), 128'(0));
      end else begin
        e = sb.pop_front();
        chk("rdata", bus.o_rdata & e.mask, e.rdata & e.mask);
        chk("fault", 128'(bus.o_fault), 128'(e.fault));
        chk("done_cycle", 128'(cyc), 128'(e.cyc));
        chk("busy_in_resp", 128'(bus.o_busy), 128'(0));
      end
    end
  end

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] sz);
    bus.i_req   = 1'b1;
    bus.i_we    = we;
    bus.i_addr  = addr;
    bus.i_wdata = wdata;
    bus.i_ctrl  = {1'b0, sz};
  endtask

  task automatic push(input logic [127:0] rd, input logic [127:0] msk, input logic flt,
                      input int at);
    exp_t e;
    e.rdata = rd; e.mask = msk; e.fault = flt; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      chk("response_timeout", 128'(sb.size()), 128'(0));
      sb.delete();
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] sz, input logic [127:0] rd, input logic [127:0] msk,
                       input logic flt);
    @(negedge CLK);
    drive(we, addr, wdata, sz);
    push(rd, msk, flt, cyc + int'(LAT) + 1);
    @(negedge CLK);
    bus.i_req = 1'b0;
    drain();
  endtask

  localparam logic [127:0] FULL = '1;
  localparam logic [127:0] M32  = 128'hFFFF_FFFF;

  initial begin
    logic [127:0] m;
    logic [31:0]  w0;
    logic [127:0] line0, line1;
    int           c0, d0;

    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_wdata = '0; bus.i_ctrl = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy",  128'(bus.o_busy),  128'(0));
    chk("rst_done",  128'(bus.o_done),  128'(0));
    chk("rst_fault", 128'(bus.o_fault), 128'(0));
    chk("rst_rdata", bus.o_rdata, '0);
    RST_X = 1'b1;

    // Zero lines 0 and 1 word by word; only already-cleared bytes are checked.
    for (int l = 0; l < 2; l++) begin
      m = '0;
      for (int k = 0; k < 4; k++) begin
        m[32*k +: 32] = '1;
        issue(1'b1, BASE + 32'(16*l + 4*k), 32'h0, 2'd2, '0, m, 1'b0);
      end
    end

    line0 = 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000;
    issue(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, line0, FULL, 1'b0);
    issue(1'b0, 32'h8000_0000, 32'h0, 2'd2, line0, FULL, 1'b0);

    line1 = 128'h0000_0000_0000_0000_0000_0000_AA00_0000;
    issue(1'b1, 32'h8000_0013, 32'h1234_56AA, 2'd0, line1, FULL, 1'b0);
    line1 = 128'hBEEF_0000_0000_0000_0000_0000_AA00_0000;
    issue(1'b1, 32'h8000_001E, 32'h1234_BEEF, 2'd1, line1, FULL, 1'b0);

    // Range boundaries and reserved size.
    issue(1'b0, 32'h7FFF_FFF0, 32'h0, 2'd2, '0, FULL, 1'b1);
    issue(1'b0, 32'h8000_4000, 32'h0, 2'd2, '0, FULL, 1'b1);
    issue(1'b0, 32'h8000_3FF0, 32'h0, 2'd2, '0, '0, 1'b0);
    issue(1'b0, 32'h8000_0000, 32'h0, 2'd3, '0, FULL, 1'b1);

    // Misaligned word store.
`ifdef MEM_RESP_ALIGN_CHECK_EN
    w0 = 32'h0;
    issue(1'b1, 32'h8000_0002, 32'hCAFE_F00D, 2'd2, '0, FULL, 1'b1);
`else
    w0 = 32'hCAFE_F00D;
    issue(1'b1, 32'h8000_0002, 32'hCAFE_F00D, 2'd2, {96'h0000_0000_0000_0000_DEAD_BEEF, w0},
          FULL, 1'b0);
`endif
    line0 = {64'h0, 32'hDEAD_BEEF, w0};
    issue(1'b0, 32'h8000_0000, 32'h0, 2'd2, line0, FULL, 1'b0);

    // Request held high through RESP is accepted again in the next IDLE cycle.
    @(negedge CLK);
    c0 = cyc;
    drive(1'b0, 32'h8000_0010, 32'h0, 2'd2);
    push(line1, FULL, 1'b0, c0 + 3);
    push(line1, FULL, 1'b0, c0 + 7);
    repeat (5) @(negedge CLK);
    bus.i_req = 1'b0;
    drain();

    // Requests pulsed during WAIT and RESP are ignored.
    d0 = n_done;
    @(negedge CLK);
    c0 = cyc;
    drive(1'b1, 32'h8000_0008, 32'h0BAD_F00D, 2'd2);
    line0 = {32'h0, 32'h0BAD_F00D, 32'hDEAD_BEEF, w0};
    push(line0, FULL, 1'b0, c0 + 3);
    @(negedge CLK);
    chk("busy_in_wait", 128'(bus.o_busy), 128'(1));
    drive(1'b1, 32'h8000_0008, 32'hFFFF_FFFF, 2'd2);
    @(negedge CLK);
    bus.i_req = 1'b0;
    @(negedge CLK);
    drive(1'b1, 32'h8000_0008, 32'hFFFF_FFFF, 2'd2);
    @(negedge CLK);
    bus.i_req = 1'b0;
    drain();
    repeat (6) @(negedge CLK);
    chk("single_done", 128'(n_done - d0), 128'(1));
    issue(1'b0, 32'h8000_0008, 32'h0, 2'd2, line0, FULL, 1'b0);

    // Reset during WAIT of a store drops the write and clears outputs at once.
    issue(1'b1, 32'h8000_0020, 32'h1122_3344, 2'd2, 128'h1122_3344, M32, 1'b0);
    @(negedge CLK);
    drive(1'b1, 32'h8000_0020, 32'h5566_7788, 2'd2);
    @(negedge CLK);
    bus.i_req = 1'b0;
    chk("busy_before_rst", 128'(bus.o_busy), 128'(1));
    #2 RST_X = 1'b0;
    #1;
    chk("async_rst_busy",  128'(bus.o_busy),  128'(0));
    chk("async_rst_done",  128'(bus.o_done),  128'(0));
    chk("async_rst_fault", 128'(bus.o_fault), 128'(0));
    chk("async_rst_rdata", bus.o_rdata, '0);
    repeat (2) @(negedge CLK);
    RST_X = 1'b1;
    issue(1'b0, 32'h8000_0020, 32'h0, 2'd2, 128'h1122_3344, M32, 1'b0);

    repeat (5) @(negedge CLK);
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
